// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one stb/ack float adder between N requesters.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead.
module adder_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*32-1:0] req_a,
  input  logic [N*32-1:0] req_b,
  input  logic [N-1:0]    req_stb,
  output logic [N-1:0]    req_ack,
  output logic [31:0]     res_z,
  output logic [N-1:0]    res_stb,
  input  logic [N-1:0]    res_ack,
  output logic [31:0]     adder_a,
  output logic            adder_a_stb,
  input  logic            adder_a_ack,
  output logic [31:0]     adder_b,
  output logic            adder_b_stb,
  input  logic            adder_b_ack,
  input  logic [31:0]     adder_z,
  input  logic            adder_z_stb,
  output logic            adder_z_ack
);

  localparam int unsigned GW = $clog2(N);

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StSendA,
    StSendB,
    StWaitZ,
    StReturn
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [31:0]   a_q, a_d, b_q, b_d, z_q, z_d;
  logic [GW-1:0] pick, idx;
`ifndef ADDER_ARB_FIXED_PRIO_EN
  logic [GW-1:0] ptr_q, ptr_d;
`endif

  // Loops run from the lowest-priority candidate up so the last hit is the winner.
  always_comb begin
    pick = '0;
    idx  = '0;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = GW'(i);
      if (req_stb[idx]) pick = idx;
    end
`else
    for (int k = int'(N); k >= 1; k--) begin
      idx = GW'((int'(ptr_q) + k) % int'(N));
      if (req_stb[idx]) pick = idx;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
`ifndef ADDER_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req_stb) begin
          grant_d = pick;
          state_d = StAccept;
        end
      end
      StAccept: begin
        // A requester dropping stb while acked forfeits its grant.
        if (req_stb[grant_q]) begin
          a_d     = req_a[32*grant_q +: 32];
          b_d     = req_b[32*grant_q +: 32];
          state_d = StSendA;
        end else begin
          state_d = StIdle;
        end
      end
      StSendA: if (adder_a_ack) state_d = StSendB;
      StSendB: if (adder_b_ack) state_d = StWaitZ;
      StWaitZ: begin
        if (adder_z_stb) begin
          z_d     = adder_z;
          state_d = StReturn;
        end
      end
      StReturn: begin
        if (res_ack[grant_q]) begin
`ifndef ADDER_ARB_FIXED_PRIO_EN
          ptr_d   = grant_q;
`endif
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      ptr_q   <= GW'(N - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    req_ack     = (state_q == StAccept) ? ({{(N-1){1'b0}}, 1'b1} << grant_q) : '0;
    res_stb     = (state_q == StReturn) ? ({{(N-1){1'b0}}, 1'b1} << grant_q) : '0;
    adder_a_stb = (state_q == StSendA);
    adder_b_stb = (state_q == StSendB);
    adder_z_ack = (state_q == StWaitZ);
    adder_a     = a_q;
    adder_b     = b_q;
    res_z       = z_q;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: table-driven scenarios against a small handshaking adder model,
// plus hand-written sequences for reset, abort and protocol-violation corners.
module tb_adder_arbiter;

  localparam int unsigned N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]    req_stb, req_ack, res_stb, res_ack;
  logic [31:0]     res_z, adder_a, adder_b, adder_z;
  logic            adder_a_stb, adder_a_ack, adder_b_stb, adder_b_ack;
  logic            adder_z_stb, adder_z_ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_stb    (req_stb),
    .req_ack    (req_ack),
    .res_z      (res_z),
    .res_stb    (res_stb),
    .res_ack    (res_ack),
    .adder_a    (adder_a),
    .adder_a_stb(adder_a_stb),
    .adder_a_ack(adder_a_ack),
    .adder_b    (adder_b),
    .adder_b_stb(adder_b_stb),
    .adder_b_ack(adder_b_ack),
    .adder_z    (adder_z),
    .adder_z_stb(adder_z_stb),
    .adder_z_ack(adder_z_ack)
  );

  // Adder model: sums only the operand pairs the bench uses.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h3FC0_0000, 32'h4020_0000}: return 32'h4080_0000;
      {32'hBF80_0000, 32'h3F80_0000}: return 32'h0000_0000;
      {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
      {32'h3F00_0000, 32'h3E80_0000}: return 32'h3F40_0000;
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  logic [1:0]  m_st;
  logic [31:0] m_a, m_b, m_z;
  int          m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_st  <= 2'd0;
      m_a   <= '0;
      m_b   <= '0;
      m_z   <= '0;
      m_cnt <= 0;
    end else begin
      case (m_st)
        2'd0: if (adder_a_stb) begin m_a <= adder_a; m_st <= 2'd1; end
        2'd1: if (adder_b_stb) begin m_b <= adder_b; m_st <= 2'd2; m_cnt <= 2; end
        2'd2: if (m_cnt == 0) begin m_z <= fadd(m_a, m_b); m_st <= 2'd3; end
              else m_cnt <= m_cnt - 1;
        default: if (adder_z_ack) m_st <= 2'd0;
      endcase
    end
  end

  assign adder_a_ack = (m_st == 2'd0);
  assign adder_b_ack = (m_st == 2'd1);
  assign adder_z_stb = (m_st == 2'd3);
  assign adder_z     = m_z;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          who;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
  } vec_t;

  vec_t vt[$];
  int   exp_order[$];
  int   grant_log[$];
  int   delay_who    = -1;
  int   delay_cycles = 0;

  function automatic int find_next(input int who, input int from);
    for (int k = from; k < vt.size(); k++) if (vt[k].who == who) return k;
    return -1;
  endfunction

  task automatic drive(input int i, input int k);
    if (k < 0) begin
      req_stb[i] = 1'b0;
    end else begin
      req_stb[i]         = 1'b1;
      req_a[32*i +: 32]  = vt[k].a;
      req_b[32*i +: 32]  = vt[k].b;
    end
  endtask

  task automatic add_vec(input int who, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] z);
    vec_t v;
    v.who = who; v.a = a; v.b = b; v.z = z;
    vt.push_back(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"}, {20'd0, req_ack, res_stb, adder_a_stb, adder_b_stb, adder_z_ack}, 32'd0);
    check({tag, "_res_z"}, res_z, 32'd0);
    check({tag, "_adder_a"}, adder_a, 32'd0);
    check({tag, "_adder_b"}, adder_b, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    req_stb = '0;
    res_ack = '0;
    req_a   = '0;
    req_b   = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs every vector in vt: each requester presents its entries in order, takes results.
  task automatic run(input string tag, input int budget);
    int          nxt[N];
    int          infl[N];
    bit          xp[N];
    int          done_n = 0;
    int          cyc    = 0;
    int          held_n = 0;
    logic [31:0] held_z = '0;
    grant_log.delete();
    res_ack = '0;
    for (int i = 0; i < int'(N); i++) begin
      nxt[i] = find_next(i, 0); infl[i] = -1; xp[i] = 1'b0; drive(i, nxt[i]);
    end
    while (done_n < vt.size() && cyc < budget) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < int'(N); i++) begin
        if (xp[i]) begin
          xp[i] = 1'b0; infl[i] = nxt[i]; nxt[i] = find_next(i, nxt[i] + 1); drive(i, nxt[i]);
        end
      end
      if (req_ack != '0) check($sformatf("%s_req_ack_onehot", tag), $onehot(req_ack), 1);
      for (int i = 0; i < int'(N); i++) begin
        if (req_ack[i]) begin
          check($sformatf("%s_ack_without_stb%0d", tag, i), req_stb[i], 1);
          xp[i] = 1'b1;
          grant_log.push_back(i);
        end
      end
      res_ack = '0;
      if (res_stb != '0) begin
        check($sformatf("%s_res_stb_onehot", tag), $onehot(res_stb), 1);
        for (int i = 0; i < int'(N); i++) begin
          if (res_stb[i]) begin
            if (infl[i] < 0) check($sformatf("%s_res_stb_unowned%0d", tag, i), res_stb, 0);
            else check($sformatf("%s_res_z_req%0d", tag, i), res_z, vt[infl[i]].z);
            if (i == delay_who && held_n < delay_cycles) begin
              if (held_n == 0) held_z = res_z;
              else check($sformatf("%s_res_z_stable", tag), res_z, held_z);
              check($sformatf("%s_adder_a_stb_in_hold", tag), adder_a_stb, 0);
              held_n++;
            end else begin
              res_ack[i] = 1'b1;
              done_n++;
            end
          end
        end
      end
    end
    check($sformatf("%s_completed", tag), done_n, vt.size());
    check($sformatf("%s_grant_count", tag), grant_log.size(), exp_order.size());
    for (int k = 0; k < exp_order.size() && k < grant_log.size(); k++)
      check($sformatf("%s_grant%0d", tag, k), grant_log[k], exp_order[k]);
    @(negedge clk);
    res_ack = '0;
    req_stb = '0;
    delay_who = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    bit ok, seen;
    rst     = 1'b1;
    req_stb = '0;
    res_ack = '0;
    req_a   = '0;
    req_b   = '0;

    // Reset values, then one transaction stepped through cycle by cycle.
    do_reset();
    check_reset_outputs("reset");
    req_stb[0]     = 1'b1;
    req_a[31:0]    = 32'h3F80_0000;
    req_b[31:0]    = 32'h4000_0000;
    @(negedge clk);
    check("t1_accept_req_ack", req_ack, 4'b0001);
    @(negedge clk);
    req_stb[0] = 1'b0;
    check("t1_send_a_req_ack", req_ack, 4'b0000);
    check("t1_send_a_stb", adder_a_stb, 1);
    check("t1_send_a_data", adder_a, 32'h3F80_0000);
    @(negedge clk);
    check("t1_send_b_stb", {adder_a_stb, adder_b_stb}, 2'b01);
    check("t1_send_b_data", adder_b, 32'h4000_0000);
    acks = 0;
    ok   = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (req_ack != '0) acks++;
      if (res_stb != '0) ok = 1'b1;
    end
    check("t1_res_seen", ok, 1);
    check("t1_extra_req_ack", acks, 0);
    for (int c = 0; c < 3; c++) begin
      check("t1_res_stb_hold", res_stb, 4'b0001);
      check("t1_res_z", res_z, 32'h4040_0000);
      @(negedge clk);
    end
    res_ack[0] = 1'b1;
    @(negedge clk);
    res_ack[0] = 1'b0;
    check("t1_res_stb_drop", res_stb, 4'b0000);

    // All four requesting at once: round-robin order and result routing.
    do_reset();
    vt.delete(); exp_order.delete();
    add_vec(0, 32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000);
    add_vec(1, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000);
    add_vec(2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    add_vec(3, 32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000);
    add_vec(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    exp_order = '{0, 1, 2, 3, 0};
    run("rr4", 400);

    // Requester 2 withholds res_ack for 20 cycles while requester 3 waits.
    do_reset();
    vt.delete(); exp_order.delete();
    add_vec(2, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    add_vec(0, 32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000);
    add_vec(3, 32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000);
    exp_order    = '{0, 2, 3};
    delay_who    = 2;
    delay_cycles = 20;
    run("delay", 400);

    // Reset while waiting on the adder aborts the transaction.
    do_reset();
    req_stb[1]      = 1'b1;
    req_a[63:32]    = 32'h3FC0_0000;
    req_b[63:32]    = 32'h4020_0000;
    ok   = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (req_ack[1]) seen = 1'b1;
      else if (seen) req_stb[1] = 1'b0;
      if (adder_z_ack) ok = 1'b1;
    end
    check("abort_wait_z_reached", ok, 1);
    rst        = 1'b1;
    req_stb[1] = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    vt.delete(); exp_order.delete();
    add_vec(1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    exp_order = '{1};
    run("after_abort", 200);

    // req_stb dropped during ACCEPT: back to IDLE, nothing sent, ptr kept.
    do_reset();
    req_stb[2]    = 1'b1;
    req_a[95:64]  = 32'h3F80_0000;
    req_b[95:64]  = 32'h3F80_0000;
    @(negedge clk);
    check("drop_accept_req_ack", req_ack, 4'b0100);
    req_stb[2] = 1'b0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (adder_a_stb || req_ack != '0) acks++;
    end
    check("drop_no_activity", acks, 0);
    vt.delete(); exp_order.delete();
    add_vec(2, 32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000);
    add_vec(3, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    exp_order = '{2, 3};
    run("drop_ptr", 200);

    // Requesters 0 and 3 continuously requesting.
    do_reset();
    vt.delete(); exp_order.delete();
    add_vec(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    add_vec(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    add_vec(0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    add_vec(3, 32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000);
    add_vec(3, 32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000);
    add_vec(3, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000);
`ifdef ADDER_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 3, 3, 3};
`else
    exp_order = '{0, 3, 0, 3, 0, 3};
`endif
    run("prio03", 500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
